// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state type and the single-cycle base ALU function for seq_alu.
// The base ALU works on 64-bit sign-extended operands so one function serves any XLEN <= 64.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_ADDO   = 5'b00001;
  localparam logic [4:0] OP_SUB    = 5'b00010;
  localparam logic [4:0] OP_SUBO   = 5'b00011;
  localparam logic [4:0] OP_AND    = 5'b00100;
  localparam logic [4:0] OP_OR     = 5'b00101;
  localparam logic [4:0] OP_XOR    = 5'b00110;
  localparam logic [4:0] OP_NOR    = 5'b00111;
  localparam logic [4:0] OP_SLTU   = 5'b01000;
  localparam logic [4:0] OP_SLT    = 5'b01001;
  localparam logic [4:0] OP_SLL    = 5'b01100;
  localparam logic [4:0] OP_SRL    = 5'b01101;
  localparam logic [4:0] OP_SRA    = 5'b01110;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operands must arrive sign-extended from xlen bits; only the low xlen result bits are meaningful.
  // Sign extension keeps both signed and unsigned ordering intact, so SLT/SLTU compare all 64 bits.
  function automatic logic [64:0] alu_base(input logic [63:0] a, input logic [63:0] b,
                                           input logic [4:0] op, input int unsigned xlen);
    logic [63:0] res;
    logic [63:0] sum;
    logic [63:0] dif;
    logic [63:0] mask;
    logic [5:0]  msb;
    logic [5:0]  sh;
    logic        ovf;
    msb  = 6'(xlen - 1);
    sh   = b[5:0] & msb;
    mask = (xlen >= 64) ? '1 : ((64'd1 << xlen) - 64'd1);
    sum  = a + b;
    dif  = a - b;
    ovf  = 1'b0;
    res  = a;
    case (op)
      OP_ADD:  res = sum;
      OP_ADDO: begin
        res = sum;
        ovf = (a[msb] == b[msb]) && (sum[msb] != a[msb]);
      end
      OP_SUB:  res = dif;
      OP_SUBO: begin
        res = dif;
        ovf = (a[msb] != b[msb]) && (dif[msb] != a[msb]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SLTU: res = {63'd0, (a < b)};
      OP_SLT:  res = {63'd0, ($signed(a) < $signed(b))};
      OP_SLL:  res = a << sh;
      // The upper copies of the sign must not shift down into the result.
      OP_SRL:  res = (a & mask) >> sh;
      OP_SRA:  res = 64'($signed(a) >>> sh);
      default: res = a;
    endcase
    return {ovf, res};
  endfunction

endpackage

// File: rtl/seq_alu_md_iter.sv
// Iterative RV32M engine: radix-2 shift-add multiply and restoring divide over XLEN cycles.
// Operands become magnitudes on start; the sign fix-up is applied to the final iteration's value.
module seq_alu_md_iter
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic              run_q, run_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              nega_q, nega_d;

  logic              is_div, sa_en, sb_en, sa, sb;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN:0]     mul_sum, div_t, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_f;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    is_div = op[2];
    sa_en  = is_div ? ~op[0] : (op[1:0] != 2'b11);
    sb_en  = is_div ? ~op[0] : ~op[1];
    sa     = sa_en & a[XLEN-1];
    sb     = sb_en & b[XLEN-1];
    ma     = sa ? (~a + 1'b1) : a;
    mb     = sb ? (~b + 1'b1) : b;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_t    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_t - {1'b0, m_q};
    div_ge   = ~div_diff[XLEN];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    step_next = op_q[2] ? div_next : mul_next;

    prod_f = neg_q ? (~step_next + 1'b1) : step_next;
    quo    = step_next[XLEN-1:0];
    rem    = step_next[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 result = prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = neg_q ? (~quo + 1'b1) : quo;
      default:                result = nega_q ? (~rem + 1'b1) : rem;
    endcase

    done = run_q && (cnt_q == '0);

    run_d  = run_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    m_d    = m_q;
    op_d   = op_q;
    neg_d  = neg_q;
    nega_d = nega_q;
    if (start) begin
      run_d  = 1'b1;
      cnt_d  = CW'(XLEN - 1);
      op_d   = op;
      neg_d  = sa ^ sb;
      nega_d = sa;
      m_d    = is_div ? mb : ma;
      acc_d  = {{XLEN{1'b0}}, (is_div ? ma : mb)};
    end else if (run_q) begin
      acc_d = step_next;
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      m_q    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      nega_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      m_q    <= m_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      nega_q <= nega_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU; RV32M multiply/divide is built only when SEQ_ALU_MD_EN is defined.
// state   | meaning
// IDLE    | no op held, ready to accept
// BUSY    | iterative M op running in seq_alu_md_iter
// DONE    | result registered and presented on out_*
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_ovf,
  output logic            out_illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            ill_q, ill_d;
  logic            accept, launch;
  logic [64:0]     base_r;

  assign base_r = alu_base(64'($signed(in_a)), 64'($signed(in_b)), in_op, unsigned'(XLEN));

  if (XLEN < 64) begin : g_base_hi
    logic unused_base_hi;
    assign unused_base_hi = ^base_r[63:XLEN];
  end

`ifdef SEQ_ALU_MD_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            md_start, md_done;
  logic [XLEN-1:0] md_result;
  logic            is_div, b_zero, div_ovf;

  assign is_div  = in_op[2];
  assign b_zero  = (in_b == '0);
  assign div_ovf = ~in_op[0] && (in_a == MOST_NEG) && (&in_b);

  seq_alu_md_iter #(.XLEN(XLEN)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (in_op[2:0]),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_result)
  );
`endif

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    launch  = 1'b0;
    accept  = in_valid && in_ready && !flush;
`ifdef SEQ_ALU_MD_EN
    md_start = 1'b0;
`endif

    case (state_q)
      ST_IDLE: launch = accept;
`ifdef SEQ_ALU_MD_EN
      ST_BUSY: begin
        if (md_done) begin
          state_d = ST_DONE;
          res_d   = md_result;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          launch  = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d = ST_DONE;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
      if (!in_op[4]) begin
        res_d = base_r[XLEN-1:0];
        ovf_d = base_r[64];
      end else begin
`ifdef SEQ_ALU_MD_EN
        // Divide corner cases bypass the iteration entirely.
        if (is_div && b_zero) begin
          res_d = in_op[1] ? in_a : '1;
        end else if (is_div && div_ovf) begin
          res_d = in_op[1] ? '0 : MOST_NEG;
        end else begin
          state_d  = ST_BUSY;
          md_start = 1'b1;
        end
`else
        res_d = '0;
        ill_d = 1'b1;
`endif
      end
    end

    if (flush) state_d = ST_IDLE;

    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32) against an arithmetic reference model.
// Expectations follow SEQ_ALU_MD_EN, so the same bench covers both builds.
module tb_seq_alu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      in_op = 5'd0;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_ovf;
  logic            out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operand values, plus the documented corner rules.
  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic v, output logic il,
                                    output int lat);
    longint      sa, sb, s;
    logic [63:0] pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = '0;
    v   = 1'b0;
    il  = 1'b0;
    lat = 1;
    if (!op[4]) begin
      case (op[3:0])
        4'd0, 4'd1: begin
          s = sa + sb;
          r = 32'(s);
          v = op[0] && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
        end
        4'd2, 4'd3: begin
          s = sa - sb;
          r = 32'(s);
          v = op[0] && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
        end
        4'd4:    r = a & b;
        4'd5:    r = a | b;
        4'd6:    r = a ^ b;
        4'd7:    r = ~(a | b);
        4'd8:    r = (a < b) ? 32'd1 : 32'd0;
        4'd9:    r = (sa < sb) ? 32'd1 : 32'd0;
        4'd12:   r = a << b[4:0];
        4'd13:   r = a >> b[4:0];
        4'd14:   r = 32'(sa >>> b[4:0]);
        default: r = a;
      endcase
    end else begin
`ifdef SEQ_ALU_MD_EN
      lat = XLEN + 1;
      case (op[2:0])
        3'd0: r = 32'(sa * sb);
        3'd1: r = 32'((sa * sb) >>> 32);
        3'd2: r = 32'((sa * longint'({32'd0, b})) >>> 32);
        3'd3: begin
          pu = {32'd0, a} * {32'd0, b};
          r  = pu[63:32];
        end
        default: begin
          if (b == 32'd0) begin
            lat = 1;
            r   = op[1] ? a : 32'hFFFF_FFFF;
          end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lat = 1;
            r   = op[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            case (op[1:0])
              2'd0:    r = 32'(sa / sb);
              2'd1:    r = a / b;
              2'd2:    r = 32'(sa % sb);
              default: r = a % b;
            endcase
          end
        end
      endcase
`else
      il = 1'b1;
      r  = '0;
`endif
    end
  endfunction

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] er;
    logic        ev, ei;
    int          el, k;
    ref_model(op, a, b, er, ev, ei, el);
    out_ready = 1'b0;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    k = 1;
    while (!out_valid && k < 200) begin
      if (k == 2) chk({tag, "_busy_rdy"}, 64'(in_ready), 64'd0);
      step();
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(el));
    chk({tag, "_res"}, 64'(out_result), 64'(er));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(ev));
    chk({tag, "_zero"}, 64'(out_zero), 64'(er == 32'd0));
    chk({tag, "_ill"}, 64'(out_illegal), 64'(ei));
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy_thru"}, 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin : main
    logic [4:0]  ops [21];
    logic [31:0] corner [6];
    logic [31:0] ra, rb, er;
    logic        ev, ei, saw;
    int          el;

    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01100, 5'b01101, 5'b01110, 5'b01111,
            5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b11101, 5'b10110};
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003};

    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    do_op(5'b00001, 32'h7FFF_FFFF, 32'h1, "addo");
    do_op(5'b00011, 32'h8000_0000, 32'h1, "subo");
    do_op(5'b01110, 32'h8000_0000, 32'd4, "sra");
    do_op(5'b01101, 32'h8000_0000, 32'd4, "srl");
    do_op(5'b01001, 32'hFFFF_FFFF, 32'd0, "slt");
    do_op(5'b01000, 32'hFFFF_FFFF, 32'd0, "sltu");
    do_op(5'b00010, 32'd5, 32'd5, "sub_zero");
    do_op(5'b01111, 32'hDEAD_BEEF, 32'd1, "passa");
    do_op(5'b10001, 32'hFFFF_FFFE, 32'd3, "mulh");
    do_op(5'b10011, 32'hFFFF_FFFE, 32'd3, "mulhu");
    do_op(5'b10100, 32'd7, 32'hFFFF_FFFE, "div");
    do_op(5'b10110, 32'd7, 32'hFFFF_FFFE, "rem");
    do_op(5'b10101, 32'h1234_5678, 32'd0, "divu_z");
    do_op(5'b10110, 32'h1234_5678, 32'd0, "rem_z");
    do_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(5'b10000, 32'd6, 32'd7, "mul");

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      do_op(ops[$urandom_range(0, 20)], ra, rb, $sformatf("rnd%0d", i));
    end

    ra = $urandom;
    rb = $urandom;
    ref_model(5'b00110, ra, rb, er, ev, ei, el);
    in_valid = 1'b1;
    in_op    = 5'b00110;
    in_a     = ra;
    in_b     = rb;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(out_result), 64'(er));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 5'b00000;
    in_a      = 32'd2;
    in_b      = 32'd3;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_res", 64'(out_result), 64'd5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    in_valid = 1'b1;
    in_op    = 5'b10100;
    in_a     = 32'd100;
    in_b     = 32'd7;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 5'b00000;
    in_a     = 32'd1;
    in_b     = 32'd1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) saw = 1'b1;
    end
    chk("flush_no_out", 64'(saw), 64'd0);

    in_valid = 1'b1;
    in_op    = 5'b10000;
    in_a     = 32'h0001_0003;
    in_b     = 32'h0000_0005;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_result", 64'(out_result), 64'd0);
    chk("mrst_zero", 64'(out_zero), 64'd0);
    chk("mrst_ovf", 64'(out_ovf), 64'd0);
    chk("mrst_ill", 64'(out_illegal), 64'd0);
    step();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) saw = 1'b1;
    end
    chk("mrst_no_out", 64'(saw), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    do_op(5'b00100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "post_rst_and");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
